// File: rtl/pinmux_safe_switch_ctrl_pkg.sv
// Shared definitions for the pinmux safe-switch sequencer and the pinmux cells.
// Holds the sequencer state encoding, the reset select default and a width helper.
package pinmux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_RESET_SEL = 0;

  // Never returns 0 so a single-entry bank or a one-cycle guard still gets a real bit.
  function automatic int unsigned clog2Min1(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/pinmux_safe_switch_ctrl_if.sv
// Valid/ready request port carrying a pad index and its new mux select.
// The register block drives the master side, the sequencer owns the slave side.
interface pinmux_safe_switch_ctrl_if #(
  parameter int IDX_WIDTH = 5,
  parameter int SEL_WIDTH = 5
);
  logic                 req_valid;
  logic                 req_ready;
  logic [IDX_WIDTH-1:0] req_pad_idx;
  logic [SEL_WIDTH-1:0] req_muxsel;

  modport master (output req_valid, output req_pad_idx, output req_muxsel, input req_ready);
  modport slave  (input req_valid, input req_pad_idx, input req_muxsel, output req_ready);
endinterface

// File: rtl/pinmux_safe_switch_ctrl_guard_timer.sv
// Loadable down-counter timing each gating phase; o_zero marks the last phase cycle.
// Loading GUARD_CYCLES-1 on phase entry gives exactly GUARD_CYCLES cycles per phase.
module pinmux_guard_timer #(
  parameter int GUARD_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_zero
);
  localparam int CW = pinmux_pkg::clog2Min1(GUARD_CYCLES + 1);

  if (GUARD_CYCLES < 1) begin : g_badGuard
    $error("pinmux_guard_timer: GUARD_CYCLES must be >= 1");
  end

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(GUARD_CYCLES - 1);
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_zero = (r_count == '0);
endmodule

// File: rtl/pinmux_safe_switch_ctrl.sv
// Break-before-make sequencer for a bank of pad mux selects: gate OE, switch, settle, ungate.
// Rejected and no-op requests finish in one cycle without touching any pad.
module pinmux_safe_switch_ctrl
  import pinmux_pkg::*;
#(
  parameter int                   NUM_PADS     = 32,
  parameter int                   SEL_WIDTH    = 5,
  parameter int                   GUARD_CYCLES = 4,
  parameter logic [SEL_WIDTH-1:0] RESET_SEL    = SEL_WIDTH'(DEFAULT_RESET_SEL),
  parameter int                   IDX_WIDTH    = clog2Min1(NUM_PADS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  pinmux_safe_switch_ctrl_if.slave      req_if,
  input  logic                          freeze_in,
  input  logic [NUM_PADS-1:0]           lock_in,
  output logic [NUM_PADS*SEL_WIDTH-1:0] muxsel_out,
  output logic [NUM_PADS-1:0]           oe_gate_out,
  output logic                          busy,
  output logic                          done_pulse,
  output logic                          err_pulse
);

  state_e               r_state;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [SEL_WIDTH-1:0] r_sel;
  logic [SEL_WIDTH-1:0] r_muxsel [NUM_PADS];
  logic [NUM_PADS-1:0]  r_gate;
  logic                 r_done;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_idxOk;
  logic                 w_locked;
  logic                 w_noop;
  logic                 w_start;
  logic                 w_zero;
  logic                 w_load;

  assign req_if.req_ready = (r_state == ST_IDLE) && !freeze_in;
  assign w_accept = req_if.req_valid && req_if.req_ready;

  // One extra bit so NUM_PADS itself is representable when the bank is a power of two.
  assign w_idxOk  = {1'b0, req_if.req_pad_idx} < (IDX_WIDTH + 1)'(NUM_PADS);
  assign w_locked = w_idxOk && lock_in[req_if.req_pad_idx];
  assign w_noop   = w_idxOk && (r_muxsel[req_if.req_pad_idx] == req_if.req_muxsel);
  assign w_start  = w_accept && w_idxOk && !w_locked && !w_noop;
  assign w_load   = w_start || ((r_state == ST_GATE) && w_zero);

  pinmux_guard_timer #(
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_guardTimer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(w_load),
    .o_zero(w_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_sel   <= '0;
      r_gate  <= '1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int k = 0; k < NUM_PADS; k++) begin
        r_muxsel[k] <= RESET_SEL;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!w_idxOk || w_locked) begin
              r_err <= 1'b1;
            end else if (w_noop) begin
              r_done <= 1'b1;
            end else begin
              r_idx                       <= req_if.req_pad_idx;
              r_sel                       <= req_if.req_muxsel;
              r_gate[req_if.req_pad_idx]  <= 1'b0;
              r_state                     <= ST_GATE;
            end
          end
        end
        ST_GATE: begin
          if (w_zero) begin
            r_muxsel[r_idx] <= r_sel;
            r_state         <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_zero) begin
            r_gate[r_idx] <= 1'b1;
            r_done        <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_PADS; k++) begin : g_muxOut
    assign muxsel_out[k*SEL_WIDTH +: SEL_WIDTH] = r_muxsel[k];
  end

  assign oe_gate_out = r_gate;
  assign busy        = (r_state != ST_IDLE);
  assign done_pulse  = r_done;
  assign err_pulse   = r_err;

endmodule

// File: tb/tb_pinmux_safe_switch_ctrl.sv
// Directed bench for pinmux_safe_switch_ctrl: a 32-pad instance for sequencing and a
// 20-pad instance for out-of-range indices; inputs change and outputs are sampled on negedge.
module tb_pinmux_safe_switch_ctrl;
  localparam int NP = 32;
  localparam int SW = 5;
  localparam int G  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pinmux_safe_switch_ctrl_if #(.IDX_WIDTH(5), .SEL_WIDTH(SW)) bus32 ();
  pinmux_safe_switch_ctrl_if #(.IDX_WIDTH(5), .SEL_WIDTH(SW)) bus20 ();

  logic            freeze32, freeze20;
  logic [NP-1:0]   lock32;
  logic [19:0]     lock20;
  logic [NP*SW-1:0] muxsel32;
  logic [20*SW-1:0] muxsel20;
  logic [NP-1:0]   gate32;
  logic [19:0]     gate20;
  logic            busy32, done32, err32, busy20, done20, err20;

  pinmux_safe_switch_ctrl #(.NUM_PADS(NP), .SEL_WIDTH(SW), .GUARD_CYCLES(G)) dut32 (
    .i_clk(clk), .i_rst(rst), .req_if(bus32), .freeze_in(freeze32), .lock_in(lock32),
    .muxsel_out(muxsel32), .oe_gate_out(gate32), .busy(busy32), .done_pulse(done32),
    .err_pulse(err32)
  );

  pinmux_safe_switch_ctrl #(.NUM_PADS(20), .SEL_WIDTH(SW), .GUARD_CYCLES(G)) dut20 (
    .i_clk(clk), .i_rst(rst), .req_if(bus20), .freeze_in(freeze20), .lock_in(lock20),
    .muxsel_out(muxsel20), .oe_gate_out(gate20), .busy(busy20), .done_pulse(done20),
    .err_pulse(err20)
  );

  int checks = 0;
  int passes = 0;
  logic [SW-1:0] expMux [NP];
  logic [NP-1:0] expGate;

  function automatic logic [NP*SW-1:0] packMux();
    logic [NP*SW-1:0] v;
    for (int k = 0; k < NP; k++) v[k*SW +: SW] = expMux[k];
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NP; k++) expMux[k] = '0;
    expGate = '1;
    @(negedge clk);
    checks++; if (muxsel32 !== packMux()) $display("[TB] FAIL reset_muxsel32: got %h expected %h", muxsel32, packMux()); else passes++;
    checks++; if (gate32 !== 32'hFFFF_FFFF) $display("[TB] FAIL reset_gate32: got %h expected ffffffff", gate32); else passes++;
    checks++; if (bus32.req_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", bus32.req_ready); else passes++;
    checks++; if (busy32 !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy32); else passes++;
    checks++; if ({done32, err32} !== 2'b00) $display("[TB] FAIL reset_pulses: got %b expected 00", {done32, err32}); else passes++;
    checks++; if (muxsel20 !== '0) $display("[TB] FAIL reset_muxsel20: got %h expected 0", muxsel20); else passes++;
    checks++; if (gate20 !== 20'hFFFFF) $display("[TB] FAIL reset_gate20: got %h expected fffff", gate20); else passes++;
  endtask

  task automatic test_normal();
    bus32.req_valid = 1'b1; bus32.req_pad_idx = 5'd3; bus32.req_muxsel = 5'd7;
    checks++; if (bus32.req_ready !== 1'b1) $display("[TB] FAIL normal_ready_T: got %b expected 1", bus32.req_ready); else passes++;
    @(negedge clk);
    bus32.req_valid = 1'b0;
    for (int i = 1; i <= 2*G + 2; i++) begin
      if (i == G + 1) expMux[3] = 5'd7;
      expGate[3] = (i <= 2*G) ? 1'b0 : 1'b1;
      checks++; if (gate32 !== expGate) $display("[TB] FAIL normal_gate c%0d: got %h expected %h", i, gate32, expGate); else passes++;
      checks++; if (muxsel32 !== packMux()) $display("[TB] FAIL normal_muxsel c%0d: got %h expected %h", i, muxsel32, packMux()); else passes++;
      checks++; if (busy32 !== (i <= 2*G)) $display("[TB] FAIL normal_busy c%0d: got %b expected %b", i, busy32, (i <= 2*G)); else passes++;
      checks++; if (done32 !== (i == 2*G + 1)) $display("[TB] FAIL normal_done c%0d: got %b expected %b", i, done32, (i == 2*G + 1)); else passes++;
      checks++; if (bus32.req_ready !== (i > 2*G)) $display("[TB] FAIL normal_ready c%0d: got %b expected %b", i, bus32.req_ready, (i > 2*G)); else passes++;
      checks++; if (err32 !== 1'b0) $display("[TB] FAIL normal_err c%0d: got %b expected 0", i, err32); else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    lock32[6] = 1'b1;
    bus32.req_valid = 1'b1; bus32.req_pad_idx = 5'd6; bus32.req_muxsel = 5'd9;
    @(negedge clk);
    bus32.req_valid = 1'b0;
    checks++; if (err32 !== 1'b1) $display("[TB] FAIL lock_err: got %b expected 1", err32); else passes++;
    checks++; if (done32 !== 1'b0) $display("[TB] FAIL lock_done: got %b expected 0", done32); else passes++;
    checks++; if (gate32 !== expGate) $display("[TB] FAIL lock_gate: got %h expected %h", gate32, expGate); else passes++;
    checks++; if (muxsel32 !== packMux()) $display("[TB] FAIL lock_muxsel: got %h expected %h", muxsel32, packMux()); else passes++;
    checks++; if (busy32 !== 1'b0) $display("[TB] FAIL lock_busy: got %b expected 0", busy32); else passes++;
    @(negedge clk);
    checks++; if (err32 !== 1'b0) $display("[TB] FAIL lock_err_pulse_width: got %b expected 0", err32); else passes++;
    lock32[6] = 1'b0;
  endtask

  task automatic test_out_of_range();
    bus20.req_valid = 1'b1; bus20.req_pad_idx = 5'd25; bus20.req_muxsel = 5'd1;
    @(negedge clk);
    bus20.req_valid = 1'b0;
    checks++; if (err20 !== 1'b1) $display("[TB] FAIL oor_err: got %b expected 1", err20); else passes++;
    checks++; if ({busy20, done20} !== 2'b00) $display("[TB] FAIL oor_busy_done: got %b expected 00", {busy20, done20}); else passes++;
    checks++; if (muxsel20 !== '0) $display("[TB] FAIL oor_muxsel: got %h expected 0", muxsel20); else passes++;
    bus20.req_valid = 1'b1; bus20.req_pad_idx = 5'd19; bus20.req_muxsel = 5'd2;
    @(negedge clk);
    bus20.req_valid = 1'b0;
    checks++; if (err20 !== 1'b0) $display("[TB] FAIL last_pad_err: got %b expected 0", err20); else passes++;
    checks++; if (gate20 !== 20'h7FFFF) $display("[TB] FAIL last_pad_gate: got %h expected 7ffff", gate20); else passes++;
    repeat (2*G) @(negedge clk);
    checks++; if (done20 !== 1'b1) $display("[TB] FAIL last_pad_done: got %b expected 1", done20); else passes++;
    checks++; if (muxsel20[19*SW +: SW] !== 5'd2) $display("[TB] FAIL last_pad_sel: got %0d expected 2", muxsel20[19*SW +: SW]); else passes++;
  endtask

  task automatic test_back_to_back();
    bus32.req_valid = 1'b1; bus32.req_pad_idx = 5'd2; bus32.req_muxsel = 5'd0;
    @(negedge clk);
    checks++; if (done32 !== 1'b1) $display("[TB] FAIL noop_done: got %b expected 1", done32); else passes++;
    checks++; if (err32 !== 1'b0) $display("[TB] FAIL noop_err: got %b expected 0", err32); else passes++;
    checks++; if (gate32 !== expGate) $display("[TB] FAIL noop_gate: got %h expected %h", gate32, expGate); else passes++;
    checks++; if (bus32.req_ready !== 1'b1) $display("[TB] FAIL noop_ready: got %b expected 1", bus32.req_ready); else passes++;
    bus32.req_muxsel = 5'd1;
    @(negedge clk);
    bus32.req_valid = 1'b0;
    expGate[2] = 1'b0;
    checks++; if (busy32 !== 1'b1) $display("[TB] FAIL b2b_busy: got %b expected 1", busy32); else passes++;
    checks++; if (gate32 !== expGate) $display("[TB] FAIL b2b_gate: got %h expected %h", gate32, expGate); else passes++;
    repeat (2*G) @(negedge clk);
    expGate[2] = 1'b1;
    expMux[2]  = 5'd1;
    checks++; if (done32 !== 1'b1) $display("[TB] FAIL b2b_done: got %b expected 1", done32); else passes++;
    checks++; if (muxsel32 !== packMux()) $display("[TB] FAIL b2b_muxsel: got %h expected %h", muxsel32, packMux()); else passes++;
    checks++; if (gate32 !== expGate) $display("[TB] FAIL b2b_gate_end: got %h expected %h", gate32, expGate); else passes++;
    @(negedge clk);
  endtask

  task automatic test_freeze();
    bus32.req_valid = 1'b1; bus32.req_pad_idx = 5'd5; bus32.req_muxsel = 5'd3;
    @(negedge clk);
    bus32.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    freeze32 = 1'b1;
    bus32.req_valid = 1'b1; bus32.req_pad_idx = 5'd8; bus32.req_muxsel = 5'd4;
    checks++; if (bus32.req_ready !== 1'b0) $display("[TB] FAIL freeze_ready_busy: got %b expected 0", bus32.req_ready); else passes++;
    repeat (2*G - 2) @(negedge clk);
    expMux[5] = 5'd3;
    checks++; if (done32 !== 1'b1) $display("[TB] FAIL freeze_done: got %b expected 1", done32); else passes++;
    checks++; if (gate32 !== expGate) $display("[TB] FAIL freeze_gate: got %h expected %h", gate32, expGate); else passes++;
    checks++; if (muxsel32 !== packMux()) $display("[TB] FAIL freeze_muxsel: got %h expected %h", muxsel32, packMux()); else passes++;
    checks++; if (bus32.req_ready !== 1'b0) $display("[TB] FAIL freeze_ready_idle: got %b expected 0", bus32.req_ready); else passes++;
    @(negedge clk);
    checks++; if (busy32 !== 1'b0) $display("[TB] FAIL freeze_held: got %b expected 0", busy32); else passes++;
    checks++; if (gate32 !== expGate) $display("[TB] FAIL freeze_held_gate: got %h expected %h", gate32, expGate); else passes++;
    freeze32 = 1'b0;
    @(negedge clk);
    bus32.req_valid = 1'b0;
    expGate[8] = 1'b0;
    checks++; if (busy32 !== 1'b1) $display("[TB] FAIL unfreeze_busy: got %b expected 1", busy32); else passes++;
    checks++; if (gate32 !== expGate) $display("[TB] FAIL unfreeze_gate: got %h expected %h", gate32, expGate); else passes++;
    repeat (2*G) @(negedge clk);
    expGate[8] = 1'b1;
    expMux[8]  = 5'd4;
    checks++; if (done32 !== 1'b1) $display("[TB] FAIL unfreeze_done: got %b expected 1", done32); else passes++;
    checks++; if (muxsel32 !== packMux()) $display("[TB] FAIL unfreeze_muxsel: got %h expected %h", muxsel32, packMux()); else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus32.req_valid = 1'b1; bus32.req_pad_idx = 5'd3; bus32.req_muxsel = 5'd12;
    @(negedge clk);
    bus32.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (muxsel32[3*SW +: SW] !== 5'd12) $display("[TB] FAIL midrst_pre_sel: got %0d expected 12", muxsel32[3*SW +: SW]); else passes++;
    checks++; if (gate32[3] !== 1'b0) $display("[TB] FAIL midrst_pre_gate: got %b expected 0", gate32[3]); else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NP; k++) expMux[k] = '0;
    expGate = '1;
    checks++; if (muxsel32 !== packMux()) $display("[TB] FAIL midrst_muxsel: got %h expected %h", muxsel32, packMux()); else passes++;
    checks++; if (gate32 !== expGate) $display("[TB] FAIL midrst_gate: got %h expected %h", gate32, expGate); else passes++;
    checks++; if (busy32 !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy32); else passes++;
    checks++; if ({done32, err32} !== 2'b00) $display("[TB] FAIL midrst_pulses: got %b expected 00", {done32, err32}); else passes++;
    @(negedge clk);
    checks++; if ({done32, err32} !== 2'b00) $display("[TB] FAIL midrst_late_pulse: got %b expected 00", {done32, err32}); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    freeze32 = 1'b0; freeze20 = 1'b0;
    lock32 = '0; lock20 = '0;
    bus32.req_valid = 1'b0; bus32.req_pad_idx = '0; bus32.req_muxsel = '0;
    bus20.req_valid = 1'b0; bus20.req_pad_idx = '0; bus20.req_muxsel = '0;
    test_reset();
    test_normal();
    test_lock();
    test_out_of_range();
    test_back_to_back();
    test_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
